memory: RTL and testbench



---
 rtl/memory.sv | 63 ++++++
 tb/tb_memory.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/memory.sv
// Single-port synchronous register-file memory with a one-cycle registered read and valid strobe.
// Define MEMORY_WR_BYPASS_EN to forward write data to a same-edge read; otherwise reads return old contents.
module memory #(
  parameter int Depth      = 4,
  parameter int Data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EN,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [Depth-1:0]      add,
  input  logic [Data_width-1:0] Data_in,
  output logic                  valid_out,
  output logic [Data_width-1:0] Data_out
);

  localparam int Words = 1 << Depth;

  logic [Data_width-1:0] r_mem [Words];
  logic [Data_width-1:0] r_data_out;
  logic                  r_valid_out;

  logic                  w_wr;
  logic                  w_rd;
  logic [Data_width-1:0] w_rd_data;

  assign w_wr = EN & wr_en;
  assign w_rd = EN & rd_en;

`ifdef MEMORY_WR_BYPASS_EN
  // Write-first: a same-edge write to the shared address wins over the stored word.
  assign w_rd_data = w_wr ? Data_in : r_mem[add];
`else
  assign w_rd_data = r_mem[add];
`endif

  // NOTE: the array is cleared by reset because the contents are architecturally
  // defined as zero after rst; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Words; i++) begin
        r_mem[i] <= '0;
      end
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the read below sample the pre-write
      // word even though the write appears first in program order.
      if (w_wr) begin
        r_mem[add] <= Data_in;
      end
      if (w_rd) begin
        r_data_out <= w_rd_data;
      end
      r_valid_out <= w_rd;
    end
  end

  assign Data_out  = r_data_out;
  assign valid_out = r_valid_out;

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: directed test-plan steps followed by random traffic,
// all compared against an array-based model of the read/write rules.
module tb_memory;

  logic        clk;
  logic        rst;
  logic        EN;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  add;
  logic [31:0] Data_in;
  logic        valid_out;
  logic [31:0] Data_out;

`ifdef MEMORY_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_mem [16];
  logic [31:0] exp_data;
  logic        exp_valid;

  memory #(.Depth(4), .Data_width(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .EN        (EN),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .add       (add),
    .Data_in   (Data_in),
    .valid_out (valid_out),
    .Data_out  (Data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    exp_data  = '0;
    exp_valid = 1'b0;
  endtask

  // Drive one access, let one rising edge pass, update the model, then compare.
  task automatic cycle(input string tag, input logic en, input logic we, input logic re,
                       input logic [3:0] a, input logic [31:0] d);
    EN = en; wr_en = we; rd_en = re; add = a; Data_in = d;
    @(posedge clk);
    if (en && re) begin
      exp_valid = 1'b1;
      exp_data  = (BYPASS && we) ? d : exp_mem[a];
    end else begin
      exp_valid = 1'b0;
    end
    if (en && we) exp_mem[a] = d;
    #1;
    check({tag, "_valid"}, {31'b0, valid_out}, {31'b0, exp_valid});
    check({tag, "_data"}, Data_out, exp_data);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; EN = 1'b0; wr_en = 1'b0; rd_en = 1'b0; add = '0; Data_in = '0;
    model_reset();

    // Reset held across an edge with a read request: nothing happens.
    EN = 1'b1; rd_en = 1'b1;
    @(posedge clk); #1;
    check("rst_hold_valid", {31'b0, valid_out}, 32'd0);
    check("rst_hold_data", Data_out, 32'd0);
    #2 rst = 1'b0;

    // Every word reads zero after reset.
    for (int i = 0; i < 16; i++) cycle("rst_read", 1'b1, 1'b0, 1'b1, 4'(i), 32'd0);

    // Write a pattern, then read all 16 back to back.
    for (int i = 0; i < 16; i++) cycle("wr", 1'b1, 1'b1, 1'b0, 4'(i), 32'hA5A5_0000 + i);
    for (int i = 0; i < 16; i++) begin
      cycle("rdback", 1'b1, 1'b0, 1'b1, 4'(i), 32'hDEAD_0000);
      check("rdback_const", Data_out, 32'hA5A5_0000 + i);
    end

    // Enable gating: the write and the read are both ignored when EN is low.
    cycle("en_off_wr", 1'b0, 1'b1, 1'b0, 4'd3, 32'hDEAD_BEEF);
    cycle("en_off_rd", 1'b0, 1'b0, 1'b1, 4'd3, 32'd0);
    cycle("en_on_rd", 1'b1, 1'b0, 1'b1, 4'd3, 32'd0);
    check("en_gate_const", Data_out, 32'hA5A5_0003);

    // Collision: same-edge write and read at address 5.
    cycle("coll_pre", 1'b1, 1'b1, 1'b0, 4'd5, 32'h1111_1111);
    cycle("coll", 1'b1, 1'b1, 1'b1, 4'd5, 32'h2222_2222);
    check("coll_const", Data_out, BYPASS ? 32'h2222_2222 : 32'h1111_1111);
    cycle("coll_after", 1'b1, 1'b0, 1'b1, 4'd5, 32'd0);
    check("coll_after_const", Data_out, 32'h2222_2222);

    // Hold: data persists with valid low while idle.
    cycle("hold_wr", 1'b1, 1'b1, 1'b0, 4'd9, 32'h1234_5678);
    cycle("hold_rd", 1'b1, 1'b0, 1'b1, 4'd9, 32'd0);
    for (int i = 0; i < 5; i++) begin
      idle("hold_idle");
      check("hold_const", Data_out, 32'h1234_5678);
    end

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      cycle("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            4'($urandom), $urandom);
    end

    // Async reset between edges while a read result is being presented.
    cycle("pre_rst_wr", 1'b1, 1'b1, 1'b0, 4'd7, 32'hCAFE_F00D);
    cycle("pre_rst_rd", 1'b1, 1'b0, 1'b1, 4'd7, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", {31'b0, valid_out}, 32'd0);
    check("async_rst_data", Data_out, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle("post_rst_rd7", 1'b1, 1'b0, 1'b1, 4'd7, 32'd0);
    check("post_rst_const", Data_out, 32'd0);
    cycle("post_rst_rd5", 1'b1, 1'b0, 1'b1, 4'd5, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
